// File: rtl/keccak_pkg.sv
// Shared constants, mode lookups and FSM state type for the Keccak absorb-side padder.
package keccak_pkg;

    localparam int unsigned W         = 64;
    localparam int unsigned MAX_RATE  = 1344;
    localparam int unsigned MAX_WORDS = MAX_RATE / W;

    localparam logic [1:0] MODE_SHAKE128 = 2'b00;
    localparam logic [1:0] MODE_SHAKE256 = 2'b01;
    localparam logic [1:0] MODE_SHA3_256 = 2'b10;
    localparam logic [1:0] MODE_SHA3_512 = 2'b11;

    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;
    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] PAD_END      = 8'h80;

    typedef enum logic [1:0] {IDLE, ABSORB, FULL} state_t;

    function automatic logic [4:0] rate_words(input logic [1:0] mode);
        logic [4:0] r;
        case (mode)
            MODE_SHAKE128: r = 5'd21;
            MODE_SHAKE256: r = 5'd17;
            MODE_SHA3_256: r = 5'd17;
            default:       r = 5'd9;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] domain_byte(input logic [1:0] mode);
        return mode[1] ? DOMAIN_SHA3 : DOMAIN_SHAKE;
    endfunction

endpackage

// File: rtl/keccak_pad_word.sv
// Pads the final message word: keeps byte_num bytes, ORs in the domain byte and,
// when the word is the block's last slot, the closing 0x80.
module keccak_pad_word
    import keccak_pkg::*;
(
    input  logic [W-1:0] i_word,
    input  logic [2:0]   i_byte_num,
    input  logic [7:0]   i_domain,
    input  logic         i_end,
    output logic [W-1:0] o_word
);

    always_comb begin
        o_word = '0;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) < i_byte_num) begin
                o_word[8*j +: 8] = i_word[8*j +: 8];
            end else if (3'(j) == i_byte_num) begin
                o_word[8*j +: 8] = i_domain;
            end
        end
        if (i_end) begin
            o_word[W-1 -: 8] = o_word[W-1 -: 8] | PAD_END;
        end
    end

endmodule

// File: rtl/keccak_padder_dilithium.sv
// Collects 64-bit words into one rate-sized block, applies FIPS-202 padding and
// holds the block on a 1344-bit bus until the permutation acknowledges it.
module keccak_padder_dilithium
    import keccak_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [W-1:0]        i_in,
    input  logic                i_in_valid,
    input  logic                i_is_last,
    input  logic [2:0]          i_byte_num,
    input  logic [1:0]          i_mode,
    output logic                o_in_ready,
    output logic [MAX_RATE-1:0] o_out,
    output logic                o_out_ready,
    output logic                o_out_last,
    input  logic                i_ack,
    output logic                o_busy
);

    state_t     r_state;
    logic [4:0] r_cnt;
    logic [1:0] r_mode;
    logic       r_in_ready;
    logic       r_out_ready;
    logic       r_out_last;
    logic       r_busy;
    logic [W-1:0] r_buf [MAX_WORDS];

    logic [1:0]   w_mode;
    logic [4:0]   w_rate;
    logic [4:0]   w_slot;
    logic [4:0]   w_end_slot;
    logic         w_at_end;
    logic         w_accept;
    logic         w_block_done;
    logic [W-1:0] w_pad;

    // Mode is taken live only on the first word; afterwards the latched copy rules.
    assign w_mode       = (r_state == IDLE) ? i_mode : r_mode;
    assign w_rate       = rate_words(w_mode);
    assign w_slot       = (r_state == IDLE) ? 5'd0 : r_cnt;
    assign w_end_slot   = w_rate - 5'd1;
    assign w_at_end     = (w_slot == w_end_slot);
    assign w_accept     = i_in_valid && r_in_ready && (r_state != FULL);
    assign w_block_done = i_is_last || w_at_end;

    keccak_pad_word u_pad_word (
        .i_word     (i_in),
        .i_byte_num (i_byte_num),
        .i_domain   (domain_byte(w_mode)),
        .i_end      (w_at_end),
        .o_word     (w_pad)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 5'd0;
            r_mode      <= MODE_SHAKE128;
            r_in_ready  <= 1'b0;
            r_out_ready <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            for (int i = 0; i < MAX_WORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE, ABSORB: begin
                    if (w_accept) begin
                        if (r_state == IDLE) begin
                            r_mode <= i_mode;
                        end
                        r_cnt  <= w_slot + 5'd1;
                        r_busy <= 1'b1;
                        if (i_is_last) begin
                            r_buf[w_slot] <= w_pad;
                            if (!w_at_end) begin
                                r_buf[w_end_slot] <= {PAD_END, 56'h0};
                            end
                        end else begin
                            r_buf[w_slot] <= i_in;
                        end
                        if (w_block_done) begin
                            r_state     <= FULL;
                            r_in_ready  <= 1'b0;
                            r_out_ready <= 1'b1;
                            r_out_last  <= i_is_last;
                        end else begin
                            r_state    <= ABSORB;
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                FULL: begin
                    if (i_ack) begin
                        for (int i = 0; i < MAX_WORDS; i++) begin
                            r_buf[i] <= '0;
                        end
                        r_cnt       <= 5'd0;
                        r_in_ready  <= 1'b1;
                        r_out_ready <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_state     <= r_out_last ? IDLE : ABSORB;
                        r_busy      <= !r_out_last;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_out = '0;
        for (int i = 0; i < MAX_WORDS; i++) begin
            o_out[MAX_RATE-1-W*i -: W] = r_buf[i];
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_ready = r_out_ready;
    assign o_out_last  = r_out_last;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_keccak_padder_dilithium.sv
// Directed bench: a byte-level FIPS-202 padding model predicts every block, a
// compare process checks each cycle a block is presented, literals pin the model.
module tb_keccak_padder_dilithium;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [63:0]    in_w;
    logic           in_valid;
    logic           is_last;
    logic [2:0]     byte_num;
    logic [1:0]     mode;
    logic           in_ready;
    logic [1343:0]  out_w;
    logic           out_ready;
    logic           out_last;
    logic           ack;
    logic           busy;

    int checks = 0;
    int errors = 0;
    logic [1343:0] exp_blk[$];
    bit            exp_last[$];
    bit            ack_en   = 1'b0;
    int            hold_cnt = 0;
    logic [1343:0] snap;

    always #5 clk = ~clk;

    keccak_padder_dilithium dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in        (in_w),
        .i_in_valid  (in_valid),
        .i_is_last   (is_last),
        .i_byte_num  (byte_num),
        .i_mode      (mode),
        .o_in_ready  (in_ready),
        .o_out       (out_w),
        .o_out_ready (out_ready),
        .o_out_last  (out_last),
        .i_ack       (ack),
        .o_busy      (busy)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] word_of(input int base, input int i);
        return 64'(base * 64 + i + 1) * 64'h9E3779B97F4A7C15;
    endfunction

    function automatic logic [63:0] out_word(input int i);
        return out_w[1343-64*i -: 64];
    endfunction

    // Byte-stream model: message bytes, domain byte, zero fill, 0x80 on the rate's last byte.
    task automatic model_msg(input logic [1:0] m, input int base, input int nfull,
                             input logic [63:0] lw, input int bn);
        byte unsigned  b[$];
        logic [63:0]   w;
        logic [1343:0] blk;
        int            rb;
        int            nblk;
        for (int i = 0; i < nfull; i++) begin
            w = word_of(base, i);
            for (int p = 0; p < 8; p++) b.push_back(w[8*p +: 8]);
        end
        for (int p = 0; p < bn; p++) b.push_back(lw[8*p +: 8]);
        rb = (m == 2'b00) ? 168 : (m == 2'b11) ? 72 : 136;
        b.push_back(m[1] ? 8'h06 : 8'h1F);
        while (b.size() % rb != 0) b.push_back(8'h00);
        b[b.size()-1] = b[b.size()-1] | 8'h80;
        nblk = b.size() / rb;
        for (int k = 0; k < nblk; k++) begin
            blk = '0;
            for (int j = 0; j < rb; j++) blk[1280-64*(j/8)+8*(j%8) +: 8] = b[k*rb+j];
            exp_blk.push_back(blk);
            exp_last.push_back(k == nblk - 1);
        end
    endtask

    task automatic send_word(input logic [63:0] d, input logic last, input logic [2:0] bn,
                             input logic [1:0] m);
        bit ok = 1'b0;
        in_w = d; is_last = last; byte_num = bn; mode = m; in_valid = 1'b1;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [1:0] m_first, input logic [1:0] m_rest, input int base,
                            input int nfull, input logic [63:0] lw, input logic [2:0] bn);
        for (int i = 0; i < nfull; i++) send_word(word_of(base, i), 1'b0, 3'd0,
                                                  (i == 0) ? m_first : m_rest);
        send_word(lw, 1'b1, bn, (nfull == 0) ? m_first : m_rest);
    endtask

    task automatic wait_release();
        bit ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1;
            if (!out_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            errors++;
            $display("FAIL release_timeout: got out_ready=1 expected 0");
        end
    endtask

    // Acknowledge driver: ack raised 1 time unit after a rising edge, held one cycle.
    initial begin
        ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (ack) ack = 1'b0;
            else if (out_ready && ack_en) begin
                if (hold_cnt >= 0) begin ack = 1'b1; hold_cnt = 0; end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_ready) begin
            checks++;
            if (exp_blk.size() == 0) begin
                errors++;
                $display("FAIL unexpected_block: got out_ready=1 expected 0");
            end else begin
                if (out_w !== exp_blk[0]) begin
                    errors++;
                    for (int i = 0; i < 21; i++) begin
                        if (out_w[1343-64*i -: 64] !== exp_blk[0][1343-64*i -: 64]) begin
                            $display("FAIL block_word%0d: got %h expected %h", i,
                                     out_w[1343-64*i -: 64], exp_blk[0][1343-64*i -: 64]);
                            break;
                        end
                    end
                end
                chk("block_last", 64'(out_last), 64'(exp_last[0]));
                chk("in_ready_in_full", 64'(in_ready), 64'd0);
                if (ack) begin
                    void'(exp_blk.pop_front());
                    void'(exp_last.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_w = '0; in_valid = 1'b0; is_last = 1'b0; byte_num = 3'd0; mode = 2'b00;
        @(negedge clk); @(negedge clk);
        chk("rst_out_ready", 64'(out_ready), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_zero", 64'(|out_w), 64'd0);
        rst_n = 1'b1;
        #1 chk("in_ready_before_clk", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("in_ready_after_clk", 64'(in_ready), 64'd1);

        // Empty SHAKE128 message; junk bytes in the word must be discarded.
        model_msg(2'b00, 0, 0, 64'hDEADBEEFCAFEF00D, 0);
        send_word(64'hDEADBEEFCAFEF00D, 1'b1, 3'd0, 2'b00);
        chk("empty_out_ready", 64'(out_ready), 64'd1);
        chk("empty_out_last", 64'(out_last), 64'd1);
        chk("empty_word0", out_word(0), 64'h000000000000001F);
        chk("empty_word20", out_word(20), 64'h8000000000000000);
        chk("empty_word10", out_word(10), 64'h0);
        chk("empty_busy", 64'(busy), 64'd1);
        ack_en = 1'b1;
        wait_release();
        chk("empty_in_ready_after_ack", 64'(in_ready), 64'd1);
        chk("empty_busy_after_ack", 64'(busy), 64'd0);

        // SHA3-512: nine full words fill block one, padding spills to block two.
        model_msg(2'b11, 1, 9, 64'h0, 0);
        send_msg(2'b11, 2'b11, 1, 9, 64'h0, 3'd0);
        chk("sha512_b2_word0", out_word(0), 64'h0000000000000006);
        chk("sha512_b2_word8", out_word(8), 64'h8000000000000000);
        chk("sha512_b2_last", 64'(out_last), 64'd1);
        wait_release();

        // SHA3-512 with byte_num=7 in the rate's last slot merges domain and end bytes.
        model_msg(2'b11, 2, 8, 64'h00AABBCCDDEEFF11, 7);
        send_msg(2'b11, 2'b11, 2, 8, 64'h00AABBCCDDEEFF11, 3'd7);
        chk("sha512_merged_word8", out_word(8), 64'h86AABBCCDDEEFF11);
        chk("sha512_merged_word9", out_word(9), 64'h0);
        wait_release();

        // Backpressure: SHA3-256 block held while extra words are offered.
        ack_en = 1'b0;
        model_msg(2'b10, 3, 3, 64'h1122334455667788, 3);
        send_msg(2'b10, 2'b10, 3, 3, 64'h1122334455667788, 3'd3);
        chk("bp_word3", out_word(3), 64'h0000000006667788);
        snap = out_w;
        for (int c = 0; c < 5; c++) begin
            in_w = 64'hBAD0BAD0BAD00000 + 64'(c); in_valid = 1'b1; is_last = 1'b0;
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_stable", 64'(out_w === snap), 64'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        ack_en = 1'b1;
        wait_release();
        chk("bp_in_ready_after_ack", 64'(in_ready), 64'd1);
        chk("bp_busy_after_ack", 64'(busy), 64'd0);

        // Mode latched as SHAKE256 on the first word, then driven to SHA3-512.
        model_msg(2'b01, 4, 12, 64'h0, 0);
        send_msg(2'b01, 2'b11, 4, 12, 64'h0, 3'd0);
        chk("mode_word8", out_word(8), word_of(4, 8));
        chk("mode_word12", out_word(12), 64'h000000000000001F);
        chk("mode_word16", out_word(16), 64'h8000000000000000);
        wait_release();

        // Reset mid-message discards five SHAKE256 words.
        for (int i = 0; i < 5; i++) send_word(word_of(5, i), 1'b0, 3'd0, 2'b01);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_ready", 64'(out_ready), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_out_zero", 64'(|out_w), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        model_msg(2'b00, 6, 0, 64'h0, 0);
        send_word(64'h0, 1'b1, 3'd0, 2'b00);
        chk("post_rst_word0", out_word(0), 64'h000000000000001F);
        chk("post_rst_word1", out_word(1), 64'h0);
        wait_release();

        for (int t = 0; t < 50 && exp_blk.size() != 0; t++) @(posedge clk);
        chk("all_blocks_seen", 64'(exp_blk.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
